// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, stall bit
// positions, the NOP encoding and the misaligned-fetch helper.
package if_stage_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned StallW      = 2;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;
  localparam logic [InstBus-1:0]     Nop      = '0;

  // ctrl stall encoding: bit 0 holds the PC, bit 1 holds the IF/ID register
  localparam int unsigned StallPcBit = 0;
  localparam int unsigned StallIdBit = 1;

  // Word fetches need the two low address bits clear
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with inst_rom chip enable and next-PC selection
// (flush > stall > branch > sequential).
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned         ADDR_W   = InstAddrBus,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [StallW-1:0] stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q;

  // Next PC; a branch seen during a PC stall is dropped because ID re-presents it
  always_comb begin
    pc_d = pc_q;
    if (!ce_q) begin
      pc_d = RESET_PC;
    end else if (flush_i) begin
      pc_d = new_pc_i;
    end else if (stall_i[StallPcBit]) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= 1'b1;
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
  assign ce_o = ce_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation toward inst_rom and the IF/ID
// pipeline register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrBus,
  parameter int unsigned       INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [StallW-1:0] stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_adel
);

  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_adel_q, id_adel_d;
  logic              adel_c;

  if_stage_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .new_pc_i        (new_pc),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .pc_o            (pc),
    .ce_o            (ce)
  );

  assign adel_c = is_misaligned(pc[1:0]);

  // IF/ID: flush and ce=0 and (stall ID only) load a bubble, full stall holds
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_adel_d = id_adel_q;
    if (flush || !ce) begin
      id_pc_d   = '0;
      id_inst_d = INST_W'(Nop);
      id_adel_d = 1'b0;
    end else if (stall[StallIdBit] && stall[StallPcBit]) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
      id_adel_d = id_adel_q;
    end else if (stall[StallIdBit]) begin
      id_pc_d   = '0;
      id_inst_d = INST_W'(Nop);
      id_adel_d = 1'b0;
    end else begin
      id_pc_d   = pc;
      id_inst_d = adel_c ? INST_W'(Nop) : inst_i;
      id_adel_d = adel_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q   <= '0;
      id_inst_q <= INST_W'(Nop);
      id_adel_q <= 1'b0;
    end else begin
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_adel_q <= id_adel_d;
    end
  end

  assign id_pc   = id_pc_q;
  assign id_inst = id_inst_q;
  assign id_adel = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small combinational instruction ROM.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] inst_i;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  logic [31:0] rom [32];
  logic [31:0] regs [32];
  int n_cmp;
  int n_err;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .inst_i        (inst_i),
    .pc            (pc),
    .ce            (ce),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_adel       (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_i = rom[pc[6:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL reset_ce got=%0b exp=0", ce); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", pc); end
    n_cmp++; if (id_inst !== 32'h0 || id_pc !== 32'h0 || id_adel !== 1'b0) begin
      n_err++; $display("FAIL reset_ifid got=%h/%h/%0b exp=0/0/0", id_pc, id_inst, id_adel);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL release_ce[%0d] got=%0b exp=1", k, ce); end
      n_cmp++; if (pc !== 32'(4 * k)) begin
        n_err++; $display("FAIL release_pc[%0d] got=%h exp=%h", k, pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL first_bubble got=%h exp=0", id_inst); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      n_cmp++; if (pc !== 32'(4 * (k - 1))) begin
        n_err++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, pc, 32'(4 * (k - 1)));
      end
      n_cmp++; if (id_pc !== 32'(4 * (k - 2)) || id_inst !== rom[k - 2]) begin
        n_err++; $display("FAIL seq_ifid[%0d] got=%h/%h exp=%h/%h", k, id_pc, id_inst, 32'(4 * (k - 2)), rom[k - 2]);
      end
      w = id_inst;
      if (w[31:26] == 6'h0D && w[20:16] != 5'd0)
        regs[w[20:16]] = regs[w[25:21]] | {16'h0, w[15:0]};
    end
    n_cmp++; if (regs[1] !== 32'h0000_1120) begin
      n_err++; $display("FAIL ori_chain_r1 got=%h exp=00001120", regs[1]);
    end
  endtask

  task automatic test_stall();
    stall = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (pc !== 32'h10 || id_pc !== 32'h0C || id_inst !== rom[3]) begin
        n_err++; $display("FAIL stall_hold[%0d] got=%h/%h/%h exp=10/0c/%h", k, pc, id_pc, id_inst, rom[3]);
      end
    end
    stall = 2'b00;
    tick();
    n_cmp++; if (pc !== 32'h14 || id_pc !== 32'h10 || id_inst !== rom[4]) begin
      n_err++; $display("FAIL stall_resume got=%h/%h/%h exp=14/10/%h", pc, id_pc, id_inst, rom[4]);
    end
  endtask

  task automatic test_bubble();
    stall = 2'b10;
    tick();
    n_cmp++; if (pc !== 32'h18 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      n_err++; $display("FAIL id_bubble got=%h/%h/%h exp=18/0/0", pc, id_pc, id_inst);
    end
    stall = 2'b00;
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    n_cmp++; if (pc !== 32'h0C) begin n_err++; $display("FAIL br_setup_pc got=%h exp=0c", pc); end
    branch_flag = 1'b1; branch_target = 32'h40;
    tick();
    branch_flag = 1'b0;
    n_cmp++; if (pc !== 32'h40 || id_pc !== 32'h0C || id_inst !== rom[3]) begin
      n_err++; $display("FAIL br_delay_slot got=%h/%h/%h exp=40/0c/%h", pc, id_pc, id_inst, rom[3]);
    end
    tick();
    n_cmp++; if (pc !== 32'h44 || id_pc !== 32'h40 || id_inst !== rom[16]) begin
      n_err++; $display("FAIL br_target got=%h/%h/%h exp=44/40/%h", pc, id_pc, id_inst, rom[16]);
    end
    stall = 2'b01; branch_flag = 1'b1; branch_target = 32'h80;
    tick();
    stall = 2'b00; branch_flag = 1'b0;
    n_cmp++; if (pc !== 32'h44) begin n_err++; $display("FAIL br_during_stall got=%h exp=44", pc); end
  endtask

  task automatic test_flush();
    stall = 2'b11; flush = 1'b1; new_pc = 32'h20;
    tick();
    stall = 2'b00; flush = 1'b0;
    n_cmp++; if (pc !== 32'h20 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
      n_err++; $display("FAIL flush got=%h/%h/%h exp=20/0/0", pc, id_pc, id_inst);
    end
    tick();
    n_cmp++; if (pc !== 32'h24 || id_pc !== 32'h20 || id_inst !== rom[8]) begin
      n_err++; $display("FAIL flush_resume got=%h/%h/%h exp=24/20/%h", pc, id_pc, id_inst, rom[8]);
    end
  endtask

  task automatic test_adel_wrap();
    branch_flag = 1'b1; branch_target = 32'h42;
    tick();
    branch_flag = 1'b0;
    n_cmp++; if (pc !== 32'h42) begin n_err++; $display("FAIL adel_pc got=%h exp=42", pc); end
    tick();
    n_cmp++; if (pc !== 32'h46 || id_pc !== 32'h42 || id_adel !== 1'b1 || id_inst !== 32'h0) begin
      n_err++; $display("FAIL adel_flag got=%h/%h/%0b/%h exp=46/42/1/0", pc, id_pc, id_adel, id_inst);
    end
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    tick();
    n_cmp++; if (pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_adel !== 1'b0 || id_inst !== rom[31]) begin
      n_err++; $display("FAIL wrap got=%h/%h/%0b/%h exp=0/fffffffc/0/%h", pc, id_pc, id_adel, id_inst, rom[31]);
    end
  endtask

  task automatic test_async_reset();
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ce !== 1'b0 || pc !== 32'h0 || id_pc !== 32'h0 || id_inst !== 32'h0 || id_adel !== 1'b0) begin
      n_err++; $display("FAIL async_reset got=%0b/%h/%h/%h/%0b exp=0/0/0/0/0", ce, pc, id_pc, id_inst, id_adel);
    end
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    stall = 2'b00;
    flush = 1'b0;
    new_pc = 32'h0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h3401_1100;
    rom[1] = 32'h3421_0020;

    test_reset();
    test_sequential();
    test_stall();
    test_bubble();
    test_branch();
    test_flush();
    test_adel_wrap();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
